db_qp_ram_ctrl: RTL and testbench
=================================

DB_QP_RAM_CTRL -- requirements
Module: db_qp_ram_ctrl

Interface
REQ-001 Parameter Word_Width, default 20, RAM word width; fields are [5:0] qp_top, [11:6] qp_top_modified, [19:12] qp_top_flag.
REQ-002 Parameter Addr_Width, default `PIC_X_WIDTH, RAM address width; depth is 1<<Addr_Width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 init_start_i  input  1  pulse; start a clear of the whole RAM.
REQ-006 busy_o  output  1  high while a clear is running.
REQ-007 req_valid_i  input  1  request valid.
REQ-008 req_ready_o  output  1  request accepted on a cycle with valid and ready both high.
REQ-009 req_op_i  input  2  operation: 0 read, 1 write, 2 flag update (RMW), 3 reserved.
REQ-010 req_addr_i  input  Addr_Width  entry address.
REQ-011 req_data_i  input  Word_Width  write data, or update operand for op 2.
REQ-012 rd_valid_o  output  1  one-cycle pulse; rd_data_o is valid.
REQ-013 rd_data_o  output  Word_Width  read result.
REQ-014 ram_cen_o, ram_oen_o, ram_wen_o  output  1 each  RAM chip, output and write enables, all low-active.
REQ-015 ram_addr_o  output  Addr_Width  RAM address.
REQ-016 ram_data_o  output  Word_Width  RAM write data.
REQ-017 ram_data_i  input  Word_Width  RAM read data; valid the cycle after a read strobe.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR and RMW_WR.
REQ-019 req_ready_o SHALL be high only in IDLE with init_start_i low.
REQ-020 RAM strobes SHALL be combinational from state and the accepted request.
  - Outside the cases below: ram_cen_o=1, ram_wen_o=1.
  - ram_oen_o SHALL be held at 0.
REQ-021 Read accepted in cycle N:
  - ram_cen_o=0 and ram_wen_o=1 in cycle N.
  - Registered rd_valid_o=1 and rd_data_o=ram_data_i in cycle N+2.
REQ-022 Write accepted in cycle N: ram_cen_o=0, ram_wen_o=0 and ram_data_o=req_data_i in cycle N; no response.
REQ-023 Flag update accepted in cycle N:
  - Cycle N: read issued; the address and operand are registered; the FSM goes to RMW_WR.
  - Cycle N+1: write to the same address of the merged word, then return to IDLE.
  - Merged word: [5:0] from RAM, [11:6] from operand, [19:12] = RAM flag OR operand flag.
  - No rd_valid_o response.
REQ-024 Op 3 SHALL be accepted and discarded, with no RAM access and no response.
REQ-025 A read issued in the cycle after a write to the same address SHALL return the new data, with no forwarding logic.
REQ-026 init_start_i in IDLE SHALL enter CLEAR and take priority over a simultaneous req_valid_i, which is not accepted.
REQ-027 CLEAR SHALL write 0 to addresses 0 .. (1<<Addr_Width)-1, one per cycle, using an address counter.
  - busy_o=1 throughout CLEAR.
  - The FSM returns to IDLE after the last address; the counter wraps to 0.
REQ-028 init_start_i SHALL be ignored outside IDLE.
REQ-029 A read accepted in the last IDLE cycle before CLEAR SHALL still deliver its rd_valid_o pulse.

Reset
REQ-030 While rst is high:
  - The FSM SHALL be in IDLE and the clear counter at 0.
  - rd_valid_o=0, rd_data_o=0, busy_o=0.
  - ram_cen_o=1, ram_wen_o=1.
  - req_ready_o SHALL be 0.
REQ-031 Reset asserted during CLEAR or RMW_WR SHALL abort the operation immediately.
  - RAM contents at the time of the abort are undefined for the verifier.
  - No rd_valid_o pulse SHALL follow.

Configuration
REQ-032 Macro DB_QP_RMW_EN:
  - Defined: op 2 SHALL behave as in REQ-023.
  - Undefined: op 2 SHALL behave as op 3 (REQ-024), and the RMW_WR state and merge logic SHALL be absent.

Verification
REQ-033 Reset, then write 0x3_0A2C to address 5, then read address 5 -> rd_valid_o two cycles after read acceptance, rd_data_o=0x3_0A2C.
REQ-034 With entry 5=0x0_10_0A (flag 0x01, modified 0x00, qp 0x0A):
  - Stimulus: op 2 with operand flag 0x02, modified 0x15.
  - Response: a read then returns flag 0x03, modified 0x15, qp 0x0A.
  - req_ready_o is low for exactly one cycle.
REQ-035 Write address 7 then read address 7 back-to-back -> the new data is returned.
REQ-036 init_start_i and req_valid_i in the same cycle:
  - busy_o high for exactly 1<<Addr_Width cycles, and the request is not accepted during that time.
  - Every subsequent read returns 0.
REQ-037 rst asserted mid-CLEAR -> the next cycle shows busy_o=0, IDLE, ram_cen_o=1; no rd_valid_o pulse.
REQ-038 With DB_QP_RMW_EN undefined, op 2 to address 5 -> no RAM strobe, and entry 5 is unchanged on readback.

Source files
------------

// File: rtl/db_qp_ram_ctrl.sv
// db_qp_ram_ctrl: QP side-info RAM controller with read/write/flag-RMW requests and full-RAM clear.
// Optional flag read-modify-write (op 2) is enabled by defining DB_QP_RMW_EN.
`ifndef PIC_X_WIDTH
`define PIC_X_WIDTH 8
`endif
module db_qp_ram_ctrl #(
   parameter int Word_Width = 20,
   parameter int Addr_Width = `PIC_X_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_start_i,
   output logic                  busy_o,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [1:0]            req_op_i,
   input  logic [Addr_Width-1:0] req_addr_i,
   input  logic [Word_Width-1:0] req_data_i,
   output logic                  rd_valid_o,
   output logic [Word_Width-1:0] rd_data_o,
   output logic                  ram_cen_o,
   output logic                  ram_oen_o,
   output logic                  ram_wen_o,
   output logic [Addr_Width-1:0] ram_addr_o,
   output logic [Word_Width-1:0] ram_data_o,
   input  logic [Word_Width-1:0] ram_data_i
);
`ifdef DB_QP_RMW_EN
   typedef enum logic [1:0] {IDLE, CLEAR, RMW_WR} state_t;
   logic [Addr_Width-1:0] r_addr;
   logic [19:6]           r_opnd;
   logic [Word_Width-1:0] w_merged;
   assign w_merged = {ram_data_i[19:12] | r_opnd[19:12], r_opnd[11:6], ram_data_i[5:0]};
`else
   typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif
   state_t                r_state, w_nxt;
   logic [Addr_Width-1:0] r_cnt;
   logic                  r_rd_p1, r_rd_valid, w_rd, w_acc;
   logic [Word_Width-1:0] r_rd_data;
   assign req_ready_o = !rst && r_state == IDLE && !init_start_i;
   assign w_acc       = req_valid_i && req_ready_o;
   assign busy_o      = r_state == CLEAR;
   assign ram_oen_o   = 1'b0;
   assign rd_valid_o  = r_rd_valid;
   assign rd_data_o   = r_rd_data;
   always_comb begin
      w_nxt      = r_state;
      ram_cen_o  = 1'b1;
      ram_wen_o  = 1'b1;
      ram_addr_o = req_addr_i;
      ram_data_o = req_data_i;
      w_rd       = 1'b0;
      case (r_state)
         IDLE:
            if (init_start_i) w_nxt = CLEAR;
            else if (w_acc)
               case (req_op_i)
                  2'd0: begin ram_cen_o = 1'b0; w_rd = 1'b1; end
                  2'd1: begin ram_cen_o = 1'b0; ram_wen_o = 1'b0; end
`ifdef DB_QP_RMW_EN
                  2'd2: begin ram_cen_o = 1'b0; w_nxt = RMW_WR; end
`endif
                  default: ;
               endcase
         CLEAR: begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_addr_o = r_cnt;
            ram_data_o = '0;
            w_nxt      = (&r_cnt) ? IDLE : CLEAR;
         end
`ifdef DB_QP_RMW_EN
         RMW_WR: begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_addr_o = r_addr;
            ram_data_o = w_merged;
            w_nxt      = IDLE;
         end
`endif
         default: w_nxt = IDLE;
      endcase
   end
   // read data arrives one cycle after the strobe and is registered on the next edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_rd_p1    <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_state    <= w_nxt;
         r_cnt      <= (r_state == CLEAR) ? r_cnt + 1'b1 : '0;
         r_rd_p1    <= w_rd;
         r_rd_valid <= r_rd_p1;
         if (r_rd_p1) r_rd_data <= ram_data_i;
      end
   end
`ifdef DB_QP_RMW_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_opnd <= '0;
      end else if (w_acc && req_op_i == 2'd2) begin
         r_addr <= req_addr_i;
         r_opnd <= req_data_i[19:6];
      end
   end
`endif
endmodule

// File: tb/tb_db_qp_ram_ctrl.sv
// tb_db_qp_ram_ctrl: directed self-checking bench with a synchronous RAM model behind the controller.
module tb_db_qp_ram_ctrl;
   localparam int AW = 4;
   localparam int WW = 20;
   logic          clk = 1'b0, rst = 1'b1, init_start_i = 1'b0, req_valid_i = 1'b0;
   logic [1:0]    req_op_i = '0;
   logic [AW-1:0] req_addr_i = '0;
   logic [WW-1:0] req_data_i = '0;
   logic          busy_o, req_ready_o, rd_valid_o, ram_cen_o, ram_oen_o, ram_wen_o;
   logic [WW-1:0] rd_data_o, ram_data_o, ram_q;
   logic [AW-1:0] ram_addr_o;
   logic [WW-1:0] mem [1<<AW];
   int            n_chk = 0, n_err = 0;
   always #5 clk = ~clk;
   db_qp_ram_ctrl #(.Word_Width(WW), .Addr_Width(AW)) dut (
      .clk(clk), .rst(rst), .init_start_i(init_start_i), .busy_o(busy_o),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .rd_valid_o(rd_valid_o),
      .rd_data_o(rd_data_o), .ram_cen_o(ram_cen_o), .ram_oen_o(ram_oen_o),
      .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
      .ram_data_i(ram_q)
   );
   initial for (int i = 0; i < (1<<AW); i++) mem[i] = 20'h5A5A5;
   always @(posedge clk)
      if (!ram_cen_o) begin
         if (!ram_wen_o) mem[ram_addr_o] <= ram_data_o;
         else ram_q <= mem[ram_addr_o];
      end
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask
   task automatic do_wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
      @(negedge clk);
      req_valid_i = 1'b1; req_op_i = 2'd1; req_addr_i = a; req_data_i = d;
      #1;
      chk("wr_strobe", {ram_cen_o, ram_wen_o, req_ready_o}, 3'b001);
      chk("wr_addr_data", {ram_addr_o, ram_data_o}, {a, d});
      @(negedge clk);
      req_valid_i = 1'b0;
   endtask
   task automatic do_rd(input logic [AW-1:0] a, output logic [WW-1:0] d);
      req_valid_i = 1'b1; req_op_i = 2'd0; req_addr_i = a;
      #1;
      chk("rd_strobe", {ram_cen_o, ram_wen_o, req_ready_o, ram_addr_o}, {3'b011, a});
      @(negedge clk);
      req_valid_i = 1'b0;
      #1 chk("rd_valid_n1", rd_valid_o, 1'b0);
      @(negedge clk);
      #1 chk("rd_valid_n2", rd_valid_o, 1'b1);
      d = rd_data_o;
      @(negedge clk);
      #1 chk("rd_valid_pulse", rd_valid_o, 1'b0);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      logic [WW-1:0] d;
      int            nb, bad;
      req_valid_i = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_outs", {busy_o, rd_valid_o, req_ready_o, ram_cen_o, ram_wen_o, ram_oen_o}, 6'b000110);
      chk("rst_rd_data", rd_data_o, 20'h0);
      req_valid_i = 1'b0;
      rst = 1'b0;
      do_wr(4'd5, 20'h30A2C);
      do_rd(4'd5, d);
      chk("rd_addr5", d, 20'h30A2C);
      do_wr(4'd7, 20'h12345);
      do_rd(4'd7, d);
      chk("wr_rd_b2b", d, 20'h12345);
      @(negedge clk);
      req_valid_i = 1'b1; req_op_i = 2'd3; req_addr_i = 4'd5; req_data_i = 20'hFFFFF;
      #1 chk("op3_nostrobe", {ram_cen_o, ram_wen_o, req_ready_o}, 3'b111);
      @(negedge clk);
      req_valid_i = 1'b0;
`ifdef DB_QP_RMW_EN
      do_wr(4'd5, {8'h01, 6'h00, 6'h0A});
      req_valid_i = 1'b1; req_op_i = 2'd2; req_addr_i = 4'd5; req_data_i = {8'h02, 6'h15, 6'h00};
      #1 chk("rmw_rd", {ram_cen_o, ram_wen_o, req_ready_o}, 3'b011);
      @(negedge clk);
      req_valid_i = 1'b0;
      #1 chk("rmw_wr", {ram_cen_o, ram_wen_o, req_ready_o, rd_valid_o}, 4'b0000);
      chk("rmw_word", {ram_addr_o, ram_data_o}, {4'd5, 8'h03, 6'h15, 6'h0A});
      @(negedge clk);
      #1 chk("rmw_done", {req_ready_o, rd_valid_o}, 2'b10);
      do_rd(4'd5, d);
      chk("rmw_readback", d, {8'h03, 6'h15, 6'h0A});
`else
      req_valid_i = 1'b1; req_op_i = 2'd2; req_addr_i = 4'd5; req_data_i = {8'h02, 6'h15, 6'h00};
      #1 chk("op2_nostrobe", {ram_cen_o, ram_wen_o, req_ready_o}, 3'b111);
      @(negedge clk);
      req_valid_i = 1'b0;
      #1 chk("op2_noresp", {req_ready_o, rd_valid_o}, 2'b10);
      do_rd(4'd5, d);
      chk("op2_unchanged", d, 20'h30A2C);
`endif
      init_start_i = 1'b1; req_valid_i = 1'b1; req_op_i = 2'd1; req_addr_i = 4'd3; req_data_i = 20'hFFFFF;
      #1 chk("init_prio", {req_ready_o, ram_cen_o, busy_o}, 3'b010);
      @(negedge clk);
      init_start_i = 1'b0;
      nb = 0; bad = 0;
      for (int i = 0; i < 40 && busy_o; i++) begin
         #1;
         if (req_ready_o || ram_cen_o || ram_wen_o || ram_data_o != 0 || ram_addr_o != nb[AW-1:0]) bad++;
         nb++;
         @(negedge clk);
      end
      req_valid_i = 1'b0;
      chk("clear_busy_len", nb, 1 << AW);
      chk("clear_strobes", bad, 0);
      do_rd(4'd0, d);  chk("clr_rd0", d, 20'h0);
      do_rd(4'd5, d);  chk("clr_rd5", d, 20'h0);
      do_rd(4'd7, d);  chk("clr_rd7", d, 20'h0);
      do_rd(4'd15, d); chk("clr_rd15", d, 20'h0);
      do_wr(4'd9, 20'hABCDE);
      req_valid_i = 1'b1; req_op_i = 2'd0; req_addr_i = 4'd9;
      @(negedge clk);
      req_valid_i = 1'b0; init_start_i = 1'b1;
      @(negedge clk);
      init_start_i = 1'b0;
      #1 chk("rd_before_clear", {rd_valid_o, busy_o, rd_data_o}, {2'b11, 20'hABCDE});
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1 chk("rst_abort", {busy_o, ram_cen_o, ram_wen_o, req_ready_o, rd_valid_o}, 5'b01100);
      @(negedge clk);
      #1 chk("rst_abort_cyc", {busy_o, ram_cen_o, rd_valid_o}, 3'b010);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1 if (rd_valid_o || busy_o || !req_ready_o) bad++;
      end
      chk("post_abort_quiet", bad, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
